// File: rtl/rename_regfile_if.sv
// Dispatch/commit/checkpoint bus of rename_regfile.
// Optional macro RF_CDB_BYPASS_EN adds the CDB snoop inputs.
interface rename_regfile_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned NCKPT   = 4,
    parameter int unsigned CKPT_AW = 2
);
    logic               rdy;
    logic               rollback;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
    logic               rs1_vld;
    logic               rs2_vld;
    logic               qj_busy;
    logic               qk_busy;
    logic [TAG_W-1:0]   qj;
    logic [TAG_W-1:0]   qk;
    logic [XLEN-1:0]    vj;
    logic [XLEN-1:0]    vk;
    logic               issue_sgn;
    logic [REG_AW-1:0]  rd;
    logic               rd_vld;
    logic [TAG_W-1:0]   rob_new_entry;
    logic               ckpt_take;
    logic [CKPT_AW-1:0] ckpt_id;
    logic               ckpt_restore;
    logic               commit_sgn;
    logic [TAG_W-1:0]   rob_entry;
    logic [REG_AW-1:0]  rob_des;
    logic               rob_des_vld;
    logic [XLEN-1:0]    rob_result;
    logic [NCKPT-1:0]   ckpt_valid;
`ifdef RF_CDB_BYPASS_EN
    logic               cdb_vld;
    logic [TAG_W-1:0]   cdb_tag;
    logic [XLEN-1:0]    cdb_value;
`endif

    modport master (
        output rdy, rollback, rs1, rs2, rs1_vld, rs2_vld,
        output issue_sgn, rd, rd_vld, rob_new_entry,
        output ckpt_take, ckpt_id, ckpt_restore,
        output commit_sgn, rob_entry, rob_des, rob_des_vld, rob_result,
`ifdef RF_CDB_BYPASS_EN
        output cdb_vld, cdb_tag, cdb_value,
`endif
        input  qj_busy, qk_busy, qj, qk, vj, vk, ckpt_valid
    );

    modport slave (
        input  rdy, rollback, rs1, rs2, rs1_vld, rs2_vld,
        input  issue_sgn, rd, rd_vld, rob_new_entry,
        input  ckpt_take, ckpt_id, ckpt_restore,
        input  commit_sgn, rob_entry, rob_des, rob_des_vld, rob_result,
`ifdef RF_CDB_BYPASS_EN
        input  cdb_vld, cdb_tag, cdb_value,
`endif
        output qj_busy, qk_busy, qj, qk, vj, vk, ckpt_valid
    );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file + rename table with NCKPT branch checkpoints.
// Optional macro RF_CDB_BYPASS_EN: operand reads also forward from the CDB.
module rename_regfile #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREG    = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned NCKPT   = 4,
    parameter int unsigned CKPT_AW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    rename_regfile_if.slave  bus
);
    logic [XLEN-1:0]                       value [NREG];
    logic [NREG-1:0]                       busy, busy_n;
    logic [NREG-1:0][TAG_W-1:0]            tag, tag_n;
    logic [NCKPT-1:0][NREG-1:0]            ck_busy, ck_busy_n;
    logic [NCKPT-1:0][NREG-1:0][TAG_W-1:0] ck_tag, ck_tag_n;
    logic [NCKPT-1:0]                      ck_vld, ck_vld_n;
    logic                                  do_commit;
    logic                                  do_issue;
    logic                                  val_we;

    assign do_commit = bus.commit_sgn && bus.rob_des_vld && (bus.rob_des != '0);
    assign do_issue  = bus.issue_sgn && bus.rd_vld && (bus.rd != '0);

    // Next-state of rename table and checkpoints
    always_comb begin
        busy_n    = busy;
        tag_n     = tag;
        ck_busy_n = ck_busy;
        ck_tag_n  = ck_tag;
        ck_vld_n  = ck_vld;
        val_we    = 1'b0;
        if (bus.rollback) begin
            busy_n   = '0;
            tag_n    = '0;
            ck_vld_n = '0;
            val_we   = do_commit;
        end else if (bus.rdy) begin
            val_we = do_commit;
            if (bus.ckpt_restore) begin
                // Restoring an empty slot leaves the live table as is
                if (ck_vld[bus.ckpt_id]) begin
                    busy_n   = ck_busy[bus.ckpt_id];
                    tag_n    = ck_tag[bus.ckpt_id];
                    ck_vld_n = '0;
                end
                if (do_commit && tag_n[bus.rob_des] == bus.rob_entry) begin
                    busy_n[bus.rob_des] = 1'b0;
                    tag_n[bus.rob_des]  = '0;
                end
            end else begin
                if (do_commit) begin
                    if (tag[bus.rob_des] == bus.rob_entry) begin
                        busy_n[bus.rob_des] = 1'b0;
                        tag_n[bus.rob_des]  = '0;
                    end
                    // Retired tags must not come back through a later restore
                    for (int unsigned k = 0; k < NCKPT; k++) begin
                        if (ck_vld[CKPT_AW'(k)] &&
                            ck_tag[CKPT_AW'(k)][bus.rob_des] == bus.rob_entry) begin
                            ck_busy_n[CKPT_AW'(k)][bus.rob_des] = 1'b0;
                            ck_tag_n[CKPT_AW'(k)][bus.rob_des]  = '0;
                        end
                    end
                end
                if (do_issue) begin
                    busy_n[bus.rd] = 1'b1;
                    tag_n[bus.rd]  = bus.rob_new_entry;
                end
                if (bus.ckpt_take) begin
                    ck_busy_n[bus.ckpt_id] = busy_n;
                    ck_tag_n[bus.ckpt_id]  = tag_n;
                    ck_vld_n[bus.ckpt_id]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) value[REG_AW'(i)] <= '0;
            busy    <= '0;
            tag     <= '0;
            ck_busy <= '0;
            ck_tag  <= '0;
            ck_vld  <= '0;
        end else begin
            busy    <= busy_n;
            tag     <= tag_n;
            ck_busy <= ck_busy_n;
            ck_tag  <= ck_tag_n;
            ck_vld  <= ck_vld_n;
            if (val_we) value[bus.rob_des] <= bus.rob_result;
        end
    end

    // Operand lookup, one instance per source port
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [REG_AW-1:0] src;
        logic              src_use;
        logic              o_busy;
        logic [TAG_W-1:0]  o_tag;
        logic [XLEN-1:0]   o_val;

        assign src     = (p == 0) ? bus.rs1 : bus.rs2;
        assign src_use = (p == 0) ? bus.rs1_vld : bus.rs2_vld;

        always_comb begin
            o_busy = 1'b0;
            o_tag  = '0;
            o_val  = '0;
            if (src_use && src != '0) begin
                if (!busy[src]) begin
                    o_val = value[src];
                end else if (bus.commit_sgn && bus.rob_des_vld && tag[src] == bus.rob_entry) begin
                    o_val = bus.rob_result;
`ifdef RF_CDB_BYPASS_EN
                end else if (bus.cdb_vld && tag[src] == bus.cdb_tag) begin
                    o_val = bus.cdb_value;
`endif
                end else begin
                    o_busy = 1'b1;
                    o_tag  = tag[src];
                end
            end
        end
    end

    assign bus.qj_busy    = g_rd[0].o_busy;
    assign bus.qj         = g_rd[0].o_tag;
    assign bus.vj         = g_rd[0].o_val;
    assign bus.qk_busy    = g_rd[1].o_busy;
    assign bus.qk         = g_rd[1].o_tag;
    assign bus.vk         = g_rd[1].o_val;
    assign bus.ckpt_valid = ck_vld;
endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file with rename (tag/busy) table for the Tomasulo/ROB core.
- Serves operand lookup at issue and value write-back at commit, with same-cycle commit forwarding.
- New relative to the previous generation: parametrised widths and depths, and NCKPT branch checkpoints of the rename table.
- A mispredict restores one snapshot instead of flushing all renames.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers (x0 hardwired zero)
REG_AW, 5, register index width, clog2(NREG)
TAG_W, 4, ROB tag width
NCKPT, 4, number of checkpoint slots
CKPT_AW, 2, checkpoint slot index width, clog2(NCKPT)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rdy  in  1  global enable; 0 = hold all state
rollback  in  1  full flush: clear every busy bit and all checkpoints
rs1 / rs2  in  REG_AW  source register indices
rs1_vld / rs2_vld  in  1  source used
qj_busy / qk_busy  out  1  operand pending in ROB
qj / qk  out  TAG_W  producing ROB tag (0 when not busy)
vj / vk  out  XLEN  operand value (0 when busy or not used)
issue_sgn  in  1  rename rd to rob_new_entry
rd  in  REG_AW  destination register
rd_vld  in  1  instruction writes rd
rob_new_entry  in  TAG_W  tag of the issuing instruction
ckpt_take  in  1  snapshot the table into slot ckpt_id
ckpt_id  in  CKPT_AW  slot to write or restore
ckpt_restore  in  1  restore the table from slot ckpt_id
commit_sgn  in  1  ROB commit
rob_entry  in  TAG_W  committing tag
rob_des  in  REG_AW  committing destination
rob_des_vld  in  1  committing instruction writes a register
rob_result  in  XLEN  committed value
ckpt_valid  out  NCKPT  per-slot valid bitmap

Behaviour:
- Reset (async, rst_n=0):
  - value[]=0, busy[]=0, tag[]=0.
  - All slots invalid, ckpt_valid=0.
  - Read outputs combinationally reflect the cleared table.
- Read path (combinational) for source s:
  - s not valid or s==0 -> busy=0, tag=0, v=0.
  - Else if busy[s]=0 -> v=value[s].
  - Else if commit_sgn && rob_des_vld && tag[s]==rob_entry -> busy=0, v=rob_result (commit forward).
  - Else busy=1, tag=tag[s], v=0.
  - Read outputs do not see the same-cycle issue.
- Sequential update priority, highest first:
  - rollback: busy[]=0, tag[]=0, all slots invalid. Values are kept, and the same-cycle commit value write still occurs.
  - rdy=0: nothing changes.
  - ckpt_restore: busy/tag tables <= slot ckpt_id. That slot and every other valid slot are invalidated (single-level flush). issue_sgn and ckpt_take in this cycle are ignored. A commit in this cycle writes value and clears busy in the restored image if the tag matches.
  - Normal cycle: commit first, then issue.
- Commit, when rob_des_vld && rob_des!=0:
  - value[rob_des] <= rob_result.
  - If tag[rob_des]==rob_entry: busy cleared and tag set to 0.
  - In every valid slot whose tag[rob_des]==rob_entry, clear that slot's busy bit, so snapshots never resurrect retired tags.
- Issue, when issue_sgn && rd_vld && rd!=0:
  - busy[rd]=1, tag[rd]=rob_new_entry.
  - Wins over a same-cycle commit to the same rd.
- ckpt_take:
  - Slot ckpt_id receives the next-state table after this cycle's commit and issue, and becomes valid.
  - Overwriting a valid slot is allowed.
  - take and restore of the same slot in one cycle: restore wins and no snapshot is taken.
- Restore of an invalid slot: no-op on the tables. The current table is kept.
- x0 is never written or renamed; the value array holds XLEN bits with no truncation.

Optional Feature:
- Macro RF_CDB_BYPASS_EN.
- When defined, add inputs cdb_vld (1), cdb_tag (TAG_W) and cdb_value (XLEN).
- If a busy source's tag matches cdb_tag while cdb_vld=1, the read path returns busy=0 and v=cdb_value.
- Commit forward has priority over the CDB match.
- Table state is unaffected by the CDB.
- When not defined, those ports do not exist and the read path is exactly as above.

Test Plan:
- Reset release, then read rs1=5, rs2=0 -> qj_busy=0, vj=0, vk=0. Commit rd=5 with 0x1234 -> next-cycle vj=0x1234.
- Issue rd=3 with tag 7, next cycle read rs1=3 -> qj_busy=1, qj=7. Commit tag 7 with 0xAA in the same read cycle -> qj_busy=0, vj=0xAA.
- Same cycle: commit rd=4 (tag 2, 0x55) and issue rd=4 with tag 9 -> value[4]=0x55, busy[4]=1, tag 9.
- Issue rd=6 with tag 1 and take slot 0, then issue rd=6 with tag 3, then restore slot 0 -> rs1=6 shows tag 1. Repeat with tag 1 committed before the restore -> busy[6]=0 after the restore.
- rdy=0 during issue and commit -> no state change. rollback with 3 busy regs and 2 valid slots -> all busy=0, ckpt_valid=0, values intact.
- rst_n asserted mid-stream (asynchronously) -> all state cleared immediately. With RF_CDB_BYPASS_EN: cdb tag 7, 0xBEEF against busy rs1 tagged 7 -> vj=0xBEEF, qj_busy=0.
